// File: rtl/rvm_core_sram.sv
// rvm_core_sram: multi-cycle RV32I core with its single-port word-wide SRAM.
//
// The core fetches, decodes, executes and does loads/stores over one shared
// bus. The bus and PC are exported so that the surroundings can spot
// pass/fail/halt addresses by watching mem_addr.
//
// Bus handshake: the core raises mem_c_en for a request, with mem_w_en for a
// write. A request completes in the cycle where mem_stall is low. While
// mem_stall is high the core holds the state and all request signals steady.
// mem_error is reported in the same cycle as the request it refers to.
//
// Ports:
//   clk        sole clock, rising edge
//   resetn     asynchronous active-low reset
//   mem_addr   bus byte address (PC outside FETCH/MEMORY)
//   mem_rdata  SRAM read data (observation)
//   mem_wdata  store data, lane-replicated (observation)
//   mem_c_en   bus request
//   mem_w_en   write request, qualified by mem_c_en
//   mem_b_en   byte-lane enables
//   mem_error  request address outside the SRAM window
//   mem_stall  SRAM stall (always 0 for this SRAM)
//   pc         current PC
//   trap       core halted on an exception; sticky until reset
module rvm_core_sram #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter string       MEMFILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_c_en,
  output logic        mem_w_en,
  output logic [3:0]  mem_b_en,
  output logic        mem_error,
  output logic        mem_stall,
  output logic [31:0] pc,
  output logic        trap
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] res_q, res_d;   // ALU result, memory address, jump target or load data

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [31:0] mem_q [MEM_WORDS];

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_dec;
  logic        legal;

  assign opcode = ir_q[6:0];
  assign rd_a   = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1_a  = ir_q[19:15];
  assign rs2_a  = ir_q[24:20];
  assign f7     = ir_q[31:25];

  always_comb begin
    imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    case (opcode)
      OP_STORE:        imm_dec = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:       imm_dec = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_dec = {ir_q[31:12], 12'b0};
      OP_JAL:          imm_dec = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:         imm_dec = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
  end

  // SYSTEM (ECALL/EBREAK) is deliberately absent so that it traps.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_JALR:   legal = (f3 == 3'b000);
      OP_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011);
      OP_LOAD:   legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                         (f3 == 3'b100) || (f3 == 3'b101);
      OP_STORE:  legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
      end
      OP_REG:    legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OP_FENCE:  legal = (f3 == 3'b000) || (f3 == 3'b001);
      default:   legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- ALU
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        br_taken;

  assign op_b  = (opcode == OP_REG) ? rs2_q : imm_q;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'b0;
    case (f3)
      3'b000: alu_res = ((opcode == OP_REG) && f7[5]) ? rs1_q - op_b : rs1_q + op_b;
      3'b001: alu_res = rs1_q << shamt;
      3'b010: alu_res = {31'b0, $signed(rs1_q) < $signed(op_b)};
      3'b011: alu_res = {31'b0, rs1_q < op_b};
      3'b100: alu_res = rs1_q ^ op_b;
      3'b101: alu_res = f7[5] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'b110: alu_res = rs1_q | op_b;
      default: alu_res = rs1_q & op_b;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000: br_taken = (rs1_q == rs2_q);
      3'b001: br_taken = (rs1_q != rs2_q);
      3'b100: br_taken = $signed(rs1_q) < $signed(rs2_q);
      3'b101: br_taken = $signed(rs1_q) >= $signed(rs2_q);
      3'b110: br_taken = rs1_q < rs2_q;
      3'b111: br_taken = rs1_q >= rs2_q;
      default: br_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- memory helpers
  logic [31:0] pc_plus4, br_target, ls_addr, rd_shift, load_val;
  logic        ls_misaligned;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_q + imm_q;
  assign ls_addr   = rs1_q + imm_q;
  assign ls_misaligned = (f3[1:0] == 2'b01) ? ls_addr[0] :
                         (f3[1:0] == 2'b10) ? (ls_addr[1:0] != 2'b00) : 1'b0;

  // Halfword accesses are 2-aligned, so the byte-lane shift also selects the half.
  assign rd_shift = mem_rdata >> {res_q[1:0], 3'b000};

  always_comb begin
    case (f3)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'b0, rd_shift[7:0]};
      3'b101:  load_val = {16'b0, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'b0;
      rs1_q   <= 32'b0;
      rs2_q   <= 32'b0;
      imm_q   <= 32'b0;
      res_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    res_d    = res_q;
    rf_we    = 1'b0;
    rf_wdata = res_q;
    case (state_q)
      S_FETCH: begin
        if (!mem_stall) begin
          if (mem_error) begin
            state_d = S_TRAP;
          end else begin
            ir_d    = mem_rdata;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_TRAP;
        end else begin
          rs1_d   = (rs1_a == 5'd0) ? 32'b0 : rf_q[rs1_a];
          rs2_d   = (rs2_a == 5'd0) ? 32'b0 : rf_q[rs2_a];
          imm_d   = imm_dec;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (opcode)
          OP_BRANCH: begin
            if (!br_taken) begin
              pc_d    = pc_plus4;
              state_d = S_FETCH;
            end else if (br_target[1]) begin
              state_d = S_TRAP;
            end else begin
              pc_d    = br_target;
              state_d = S_FETCH;
            end
          end
          OP_LOAD, OP_STORE: begin
            res_d   = ls_addr;
            state_d = ls_misaligned ? S_TRAP : S_MEMORY;
          end
          OP_JAL:   res_d = br_target;
          OP_JALR:  res_d = ls_addr & ~32'd1;
          OP_LUI:   res_d = imm_q;
          OP_AUIPC: res_d = br_target;
          OP_IMM, OP_REG: res_d = alu_res;
          default:  res_d = res_q;   // FENCE: nothing to compute
        endcase
      end
      S_MEMORY: begin
        if (!mem_stall) begin
          if (mem_error) begin
            state_d = S_TRAP;
          end else if (opcode == OP_STORE) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            res_d   = load_val;
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
          // A misaligned jump target halts before rd is touched.
          if (res_q[1]) begin
            state_d = S_TRAP;
          end else begin
            rf_we    = 1'b1;
            rf_wdata = pc_plus4;
            pc_d     = res_q;
            state_d  = S_FETCH;
          end
        end else begin
          rf_we   = (opcode != OP_FENCE);
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_TRAP;
    endcase
  end

  // ---------------------------------------------------------------- bus outputs
  // Everything is forced quiet while resetn is low so no request leaks out.
  always_comb begin
    mem_addr  = pc_q;
    mem_c_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_b_en  = 4'b0000;
    mem_wdata = 32'b0;
    if (resetn) begin
      case (state_q)
        S_FETCH: begin
          mem_c_en = 1'b1;
          mem_b_en = 4'b1111;
        end
        S_MEMORY: begin
          mem_addr = res_q;
          mem_c_en = 1'b1;
          mem_b_en = 4'b1111;
          if (opcode == OP_STORE) begin
            mem_w_en = 1'b1;
            case (f3[1:0])
              2'b00: begin
                mem_wdata = {4{rs2_q[7:0]}};
                mem_b_en  = 4'b0001 << res_q[1:0];
              end
              2'b01: begin
                mem_wdata = {2{rs2_q[15:0]}};
                mem_b_en  = 4'b0011 << {res_q[1], 1'b0};
              end
              default: mem_wdata = rs2_q;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign pc   = pc_q;
  assign trap = (state_q == S_TRAP);

  // ---------------------------------------------------------------- register file
  always_ff @(posedge clk) begin
    if (rf_we && (rd_a != 5'd0)) rf_q[rd_a] <= rf_wdata;
  end

  // ---------------------------------------------------------------- SRAM
  logic [31:0] mem_offset;
  logic        in_range;
  logic [AW-1:0] word_idx;

  // Addresses below MEM_BASE wrap to large offsets, so one compare covers both ends.
  assign mem_offset = mem_addr - MEM_BASE;
  assign in_range   = (mem_offset < MEM_BYTES);
  assign word_idx   = mem_offset[AW+1:2];
  assign mem_rdata  = in_range ? mem_q[word_idx] : 32'b0;
  assign mem_error  = mem_c_en & ~in_range;
  assign mem_stall  = 1'b0;

  always_ff @(posedge clk) begin
    if (mem_c_en && mem_w_en && !mem_error) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_b_en[i]) mem_q[word_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rvm_core_sram.sv
module tb_rvm_core_sram;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr, mem_rdata, mem_wdata, pc;
  logic        mem_c_en, mem_w_en, mem_error, mem_stall, trap;
  logic [3:0]  mem_b_en;

  int checks = 0;
  int errors = 0;

  // Expected store transactions: {addr, byte enables, write data}.
  logic [67:0] exp_q[$];

  localparam logic [31:0] BASE = 32'h8000_0000;

  rvm_core_sram dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_c_en  (mem_c_en),
    .mem_w_en  (mem_w_en),
    .mem_b_en  (mem_b_en),
    .mem_error (mem_error),
    .mem_stall (mem_stall),
    .pc        (pc),
    .trap      (trap)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.mem_q[idx] <= w;
  endtask

  task automatic begin_reset();
    resetn = 1'b0;
    for (int i = 0; i < 128; i++) dut.mem_q[i] <= 32'b0;
  endtask

  task automatic end_reset();
    cycles(3);
    check32("rst_pc", pc, BASE);
    check32("rst_addr", mem_addr, BASE);
    check32("rst_c_en", {31'b0, mem_c_en}, 32'd0);
    check32("rst_trap", {31'b0, trap}, 32'd0);
    check32("rst_w_b_en", {27'b0, mem_w_en, mem_b_en}, 32'd0);
    check32("rst_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;
    #1;
    check32("first_fetch_c_en", {31'b0, mem_c_en}, 32'd1);
  endtask

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (resetn && mem_c_en && mem_w_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL store_unexpected: observed %h/%b/%h expected none", mem_addr, mem_b_en, mem_wdata);
      end else begin
        logic [67:0] exp;
        exp = exp_q.pop_front();
        assert ({mem_addr, mem_b_en, mem_wdata} === exp) else begin
          errors++;
          $error("FAIL store: observed %h/%b/%h expected %h/%b/%h",
                 mem_addr, mem_b_en, mem_wdata, exp[67:36], exp[35:32], exp[31:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- directed sequence
  initial begin
    resetn = 1'b1;
    @(negedge clk);

    // ALU pair then illegal all-zero word
    begin_reset();
    put(0, 32'h00500093);   // addi x1,x0,5
    put(1, 32'hFFD08113);   // addi x2,x1,-3
    end_reset();
    cycles(7);
    check32("alu_pc_7", pc, BASE + 32'h4);
    cycles(1);
    check32("alu_pc_8", pc, BASE + 32'h8);
    check32("alu_x1", dut.rf_q[1], 32'd5);
    check32("alu_x2", dut.rf_q[2], 32'd2);
    cycles(2);
    check32("illegal_trap", {31'b0, trap}, 32'd1);
    check32("illegal_c_en", {31'b0, mem_c_en}, 32'd0);
    check32("illegal_pc", pc, BASE + 32'h8);
    cycles(5);
    check32("illegal_trap_sticky", {31'b0, trap}, 32'd1);
    check32("illegal_pc_frozen", pc, BASE + 32'h8);
    check32("illegal_c_en_later", {31'b0, mem_c_en}, 32'd0);

    // Byte/half/word stores, loads, ALU ops, branch and JAL loop
    begin_reset();
    put(0,  32'h800001B7);  // lui  x3,0x80000
    put(1,  32'h10018193);  // addi x3,x3,0x100
    put(2,  32'hF8000213);  // addi x4,x0,-128
    put(3,  32'h004180A3);  // sb   x4,1(x3)
    put(4,  32'h00118283);  // lb   x5,1(x3)
    put(5,  32'h0011C303);  // lbu  x6,1(x3)
    put(6,  32'h00419123);  // sh   x4,2(x3)
    put(7,  32'h0051A223);  // sw   x5,4(x3)
    put(8,  32'h404303B3);  // sub  x7,x6,x4
    put(9,  32'h0071A423);  // sw   x7,8(x3)
    put(10, 32'h00022433);  // slt  x8,x4,x0
    put(11, 32'h000234B3);  // sltu x9,x4,x0
    put(12, 32'h40425513);  // srai x10,x4,4
    put(13, 32'h01C25593);  // srli x11,x4,28
    put(14, 32'h00000463);  // beq  x0,x0,+8
    put(15, 32'h00000000);  // skipped
    put(16, 32'h000000EF);  // jal  x1,0
    exp_q.push_back({32'h80000101, 4'b0010, 32'h80808080});
    exp_q.push_back({32'h80000102, 4'b1100, 32'hFF80FF80});
    exp_q.push_back({32'h80000104, 4'b1111, 32'hFFFFFF80});
    exp_q.push_back({32'h80000108, 4'b1111, 32'h00000100});
    end_reset();
    cycles(58);
    check32("seq_pc_58", pc, BASE + 32'h38);
    check32("x3", dut.rf_q[3], 32'h80000100);
    check32("x4", dut.rf_q[4], 32'hFFFFFF80);
    check32("lb_x5", dut.rf_q[5], 32'hFFFFFF80);
    check32("lbu_x6", dut.rf_q[6], 32'h00000080);
    check32("sub_x7", dut.rf_q[7], 32'h00000100);
    check32("slt_x8", dut.rf_q[8], 32'd1);
    check32("sltu_x9", dut.rf_q[9], 32'd0);
    check32("srai_x10", dut.rf_q[10], 32'hFFFFFFF8);
    check32("srli_x11", dut.rf_q[11], 32'h0000000F);
    check32("mem_w64", dut.mem_q[64], 32'hFF808000);
    check32("mem_w65", dut.mem_q[65], 32'hFFFFFF80);
    check32("mem_w66", dut.mem_q[66], 32'h00000100);
    cycles(2);
    check32("beq_pc_in_flight", pc, BASE + 32'h38);
    cycles(1);
    check32("beq_pc_taken", pc, BASE + 32'h40);
    check32("jal_fetch_addr_0", mem_addr, BASE + 32'h40);
    check32("jal_fetch_c_en_0", {31'b0, mem_c_en}, 32'd1);
    cycles(4);
    check32("jal_fetch_addr_1", mem_addr, BASE + 32'h40);
    check32("jal_x1", dut.rf_q[1], BASE + 32'h44);
    cycles(4);
    check32("jal_fetch_addr_2", mem_addr, BASE + 32'h40);
    check32("jal_fetch_c_en_2", {31'b0, mem_c_en}, 32'd1);
    check32("stores_drained", 32'(exp_q.size()), 32'd0);

    // Misaligned LW traps in EXECUTE
    begin_reset();
    put(0, 32'h800001B7);   // lui x3,0x80000
    put(1, 32'h0021A283);   // lw  x5,2(x3)
    end_reset();
    cycles(6);
    check32("mis_no_trap_yet", {31'b0, trap}, 32'd0);
    cycles(1);
    check32("mis_trap", {31'b0, trap}, 32'd1);
    check32("mis_pc", pc, BASE + 32'h4);
    check32("mis_c_en", {31'b0, mem_c_en}, 32'd0);

    // Out-of-range LW raises mem_error and leaves rd alone
    begin_reset();
    put(0, 32'h12300293);   // addi x5,x0,0x123
    put(1, 32'h00002283);   // lw   x5,0(x0)
    end_reset();
    cycles(7);
    check32("err_flag", {31'b0, mem_error}, 32'd1);
    check32("err_addr", mem_addr, 32'h0);
    check32("err_c_en", {31'b0, mem_c_en}, 32'd1);
    cycles(1);
    check32("err_trap", {31'b0, trap}, 32'd1);
    check32("err_x5_kept", dut.rf_q[5], 32'h00000123);
    check32("err_pc", pc, BASE + 32'h4);
    check32("err_no_stores", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
